stump_alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the Stump single-cycle ALU. Performs the Stump arithmetic/logic set in one clock and adds an iterative shift-and-add multiplier (low and high product halves), with registered result, a registered NZVC flag store and a start/busy/done handshake. Sits in the execute stage between the register-file read ports and the write-back mux; the control FSM stalls on `busy`.

---
 rtl/stump_alu_pkg.sv | 44 ++++
 rtl/stump_alu_comb.sv | 99 +++++++++
 rtl/stump_alu_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_stump_alu_mc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stump_alu_pkg.sv
// -----------------------------------------------------------------------------
// stump_alu_pkg
// Shared definitions for the multi-cycle Stump ALU:
//   - function codes (ADD..OR, LDST, BCC, MUL, MULH)
//   - bit positions of the {N,Z,V,C} flag vector
//   - control FSM state encoding
//   - small helpers that classify function codes
// -----------------------------------------------------------------------------
package stump_alu_pkg;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] ADC  = 4'b0001;
  localparam logic [3:0] SUB  = 4'b0010;
  localparam logic [3:0] SBC  = 4'b0011;
  localparam logic [3:0] AND  = 4'b0100;
  localparam logic [3:0] OR   = 4'b0101;
  localparam logic [3:0] LDST = 4'b0110;  // address add, never writes flags
  localparam logic [3:0] BCC  = 4'b0111;  // address add, never writes flags
  localparam logic [3:0] MUL  = 4'b1000;
  localparam logic [3:0] MULH = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True for the two multiply function codes.
  function automatic logic is_mul_func(input logic [3:0] f);
    return (f == MUL) || (f == MULH);
  endfunction

  // True for codes whose completion may update the flag register
  // (ADD..OR and the multiplies); LDST/BCC and reserved codes never do.
  function automatic logic flags_writable(input logic [3:0] f);
    return (f <= OR) || is_mul_func(f);
  endfunction

endpackage

// File: rtl/stump_alu_comb.sv
// -----------------------------------------------------------------------------
// stump_alu_comb
// Combinational add/logic unit with {N,Z,V,C} generation. Also used by the
// multiplier as its accumulate adder (driven with func=ADD).
// Ports:
//   i_func    function code (ADD..OR, LDST, BCC; anything else gives 0)
//   i_a, i_b  operands
//   i_cin     carry in for ADC/SBC
//   i_csh     shifter carry, reported as C for AND/OR
//   o_result  WIDTH-bit result
//   o_flags   {N,Z,V,C}; for ADD the C bit is the adder carry out
// -----------------------------------------------------------------------------
module stump_alu_comb
  import stump_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       i_func,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_csh,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic             w_arith;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // Select the effective addend and carry in; subtracts add the inverted B.
  always_comb begin
    w_b_eff   = i_b;
    w_cin_eff = 1'b0;
    w_arith   = 1'b1;
    case (i_func)
      ADD, LDST, BCC: begin
        w_b_eff   = i_b;
        w_cin_eff = 1'b0;
      end
      ADC: w_cin_eff = i_cin;
      SUB: begin
        w_b_eff   = ~i_b;
        w_cin_eff = 1'b1;
      end
      SBC: begin
        w_b_eff   = ~i_b;
        w_cin_eff = i_cin;
      end
      default: w_arith = 1'b0;
    endcase
  end

  // One extra bit so the carry out lands in w_sum[WIDTH].
  assign w_sum = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};

  // Result, carry and overflow for arithmetic and logic operations.
  always_comb begin
    w_res = {WIDTH{1'b0}};
    w_c   = 1'b0;
    w_v   = 1'b0;
    if (w_arith) begin
      w_res = w_sum[WIDTH-1:0];
      w_c   = w_sum[WIDTH];
      w_v   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
              (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    end else begin
      case (i_func)
        AND: begin
          w_res = i_a & i_b;
          w_c   = i_csh;
        end
        OR: begin
          w_res = i_a | i_b;
          w_c   = i_csh;
        end
        default: begin
          w_res = {WIDTH{1'b0}};
          w_c   = 1'b0;
        end
      endcase
    end
  end

  // Drive result and assemble the flag vector.
  always_comb begin
    o_result        = w_res;
    o_flags         = 4'b0000;
    o_flags[FLAG_N] = w_res[WIDTH-1];
    o_flags[FLAG_Z] = (w_res == {WIDTH{1'b0}});
    o_flags[FLAG_V] = w_v;
    o_flags[FLAG_C] = w_c;
  end

endmodule

// File: rtl/stump_alu_mc.sv
// -----------------------------------------------------------------------------
// stump_alu_mc
// Multi-cycle Stump ALU: single-cycle add/logic operations plus an iterative
// shift-and-add multiplier (low or high product half). Result and flags are
// registered; start/busy/done handshake towards the control FSM.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               issue an operation (ignored while busy)
//   func                function code (see stump_alu_pkg)
//   operand_A/B         operands
//   c_in                carry in for ADC/SBC
//   csh                 shifter carry, used as C for AND/OR
//   flag_en             update flags on completion
//   busy                multiply in progress
//   done                one-cycle completion pulse
//   result              registered result, held until next completion
//   flags_out           registered {N,Z,V,C}
// -----------------------------------------------------------------------------
module stump_alu_mc
  import stump_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             c_in,
  input  logic             csh,
  input  logic             flag_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out
);

  localparam int            CW       = $clog2(WIDTH + 1);
  // The first multiply step is taken in the issue cycle, so WIDTH-1 remain.
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_mulh;
  logic               r_flag_en;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   w_result_nxt;
  logic [3:0]         r_flags;
  logic [3:0]         w_flags_nxt;
  logic               r_busy;
  logic               r_done;
  logic               w_done_nxt;

  logic [3:0]         w_eff_func;
  logic               w_mul_issue;
  logic [3:0]         w_cmb_func;
  logic [WIDTH-1:0]   w_cmb_a;
  logic [WIDTH-1:0]   w_cmb_b;
  logic [WIDTH-1:0]   w_cmb_res;
  logic [3:0]         w_cmb_flags;
  logic [WIDTH-1:0]   w_prod_lo;
  logic [WIDTH-1:0]   w_prod_hi;
  logic [3:0]         w_mul_flags;

  // With the multiplier disabled, MUL/MULH behave exactly like ADD.
  assign w_eff_func  = (is_mul_func(func) && !MUL_EN) ? ADD : func;
  assign w_mul_issue = (r_state == ST_IDLE) && start && is_mul_func(w_eff_func);
  assign w_prod_lo   = r_acc[WIDTH-1:0];
  assign w_prod_hi   = r_acc[2*WIDTH-1:WIDTH];

  // Steer the shared adder: normal operation, or one accumulate step.
  always_comb begin
    w_cmb_func = w_eff_func;
    w_cmb_a    = operand_A;
    w_cmb_b    = operand_B;
    if (r_state == ST_MUL) begin
      w_cmb_func = ADD;
      w_cmb_a    = w_prod_hi;
      w_cmb_b    = r_acc[0] ? r_mcand : {WIDTH{1'b0}};
    end else if (w_mul_issue) begin
      // First step straight from the operands: high half is still zero.
      w_cmb_func = ADD;
      w_cmb_a    = {WIDTH{1'b0}};
      w_cmb_b    = operand_B[0] ? operand_A : {WIDTH{1'b0}};
    end else begin
      w_cmb_func = w_eff_func;
      w_cmb_a    = operand_A;
      w_cmb_b    = operand_B;
    end
  end

  stump_alu_comb #(
    .WIDTH    (WIDTH)
  ) u_comb (
    .i_func   (w_cmb_func),
    .i_a      (w_cmb_a),
    .i_b      (w_cmb_b),
    .i_cin    (c_in),
    .i_csh    (csh),
    .o_result (w_cmb_res),
    .o_flags  (w_cmb_flags)
  );

  // Flags reported at multiply completion; V on MUL flags a lost high half.
  always_comb begin
    w_mul_flags = 4'b0000;
    if (r_mulh) begin
      w_mul_flags[FLAG_N] = w_prod_hi[WIDTH-1];
      w_mul_flags[FLAG_Z] = (w_prod_hi == {WIDTH{1'b0}});
      w_mul_flags[FLAG_V] = 1'b0;
    end else begin
      w_mul_flags[FLAG_N] = w_prod_lo[WIDTH-1];
      w_mul_flags[FLAG_Z] = (w_prod_lo == {WIDTH{1'b0}});
      w_mul_flags[FLAG_V] = (w_prod_hi != {WIDTH{1'b0}});
    end
    w_mul_flags[FLAG_C] = 1'b0;
  end

  // Next-state, accumulator, counter and completion logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_mul_func(w_eff_func)) begin
            w_state_nxt = ST_MUL;
            // Shift {carry, sum, multiplier} right by one.
            w_acc_nxt   = {w_cmb_flags[FLAG_C], w_cmb_res, operand_B[WIDTH-1:1]};
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_result_nxt = w_cmb_res;
            w_done_nxt   = 1'b1;
            if (flag_en && flags_writable(w_eff_func)) begin
              w_flags_nxt = w_cmb_flags;
            end else begin
              w_flags_nxt = r_flags;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_acc_nxt = {w_cmb_flags[FLAG_C], w_cmb_res, r_acc[WIDTH-1:1]};
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_DONE: begin
        w_state_nxt  = ST_IDLE;
        w_done_nxt   = 1'b1;
        w_result_nxt = r_mulh ? w_prod_hi : w_prod_lo;
        if (r_flag_en) begin
          w_flags_nxt = w_mul_flags;
        end else begin
          w_flags_nxt = r_flags;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers, operand capture and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= {(2*WIDTH){1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_mcand   <= {WIDTH{1'b0}};
      r_mulh    <= 1'b0;
      r_flag_en <= 1'b0;
      r_result  <= {WIDTH{1'b0}};
      r_flags   <= 4'b0000;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_flags  <= w_flags_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= w_done_nxt;
      if (w_mul_issue) begin
        r_mcand   <= operand_A;
        r_mulh    <= (func == MULH);
        r_flag_en <= flag_en;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign flags_out = r_flags;

endmodule

// File: tb/tb_stump_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_stump_alu_mc
// Self-checking bench for stump_alu_mc (WIDTH=16, MUL_EN=1). Directed cases
// followed by randomized operations, compared against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_stump_alu_mc;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    func;
  logic [W-1:0]  operand_A;
  logic [W-1:0]  operand_B;
  logic          c_in;
  logic          csh;
  logic          flag_en;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [3:0]    flags_out;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   m_result;
  logic [3:0]    m_flags;

  stump_alu_mc #(
    .WIDTH     (W),
    .MUL_EN    (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .func      (func),
    .operand_A (operand_A),
    .operand_B (operand_B),
    .c_in      (c_in),
    .csh       (csh),
    .flag_en   (flag_en),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags_out (flags_out)
  );

  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the operation definitions using plain integers.
  task automatic model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic cs, input logic fe,
                       output logic [15:0] r, output logic wr, output logic [3:0] fl);
    int              sa, sb, sv, uv;
    logic            c, v;
    longint unsigned p;
    sa = $signed(a);
    sb = $signed(b);
    p  = longint'(a) * longint'(b);
    c  = 1'b0;
    v  = 1'b0;
    r  = 16'h0000;
    wr = fe;
    case (f)
      4'd0, 4'd6, 4'd7: begin
        uv = int'(a) + int'(b);
        sv = sa + sb;
        r  = sv[15:0];
        c  = uv[16];
        v  = (sv > 32767) || (sv < -32768);
        if (f != 4'd0) wr = 1'b0;
      end
      4'd1: begin
        uv = int'(a) + int'(b) + int'(ci);
        sv = sa + sb + int'(ci);
        r  = sv[15:0];
        c  = uv[16];
        v  = (sv > 32767) || (sv < -32768);
      end
      4'd2: begin
        sv = sa - sb;
        r  = sv[15:0];
        c  = (a >= b);
        v  = (sv > 32767) || (sv < -32768);
      end
      4'd3: begin
        sv = sa - sb - 1 + int'(ci);
        r  = sv[15:0];
        c  = (int'(a) + int'(ci)) > int'(b);
        v  = (sv > 32767) || (sv < -32768);
      end
      4'd4: begin r = a & b; c = cs; end
      4'd5: begin r = a | b; c = cs; end
      4'd8: begin r = p[15:0];  v = (p[31:16] != 16'h0000); end
      4'd9: begin r = p[31:16]; end
      default: begin r = 16'h0000; wr = 1'b0; end
    endcase
    fl = {r[15], (r == 16'h0000), v, c};
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic scramble();
    func      = 4'($urandom);
    operand_A = 16'($urandom);
    operand_B = 16'($urandom);
    c_in      = 1'($urandom);
    csh       = 1'($urandom);
    flag_en   = 1'($urandom);
  endtask

  // Issue one operation, wait for its completion and check it.
  task automatic do_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic cs, input logic fe);
    logic [15:0] er;
    logic        ew;
    logic [3:0]  ef;
    int          n;
    model(f, a, b, ci, cs, fe, er, ew, ef);
    func = f; operand_A = a; operand_B = b; c_in = ci; csh = cs; flag_en = fe;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    if (f == 4'd8 || f == 4'd9) begin
      n = 1;
      while (done !== 1'b1 && n < 40) begin
        chk("mul_busy", {31'd0, busy}, 32'd1);
        start = 1'($urandom);  // must be ignored while busy
        scramble();
        @(posedge clk); #1;
        n++;
      end
      start = 1'b0;
      chk("mul_latency", n, 32'd17);
    end
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("done", {31'd0, done}, 32'd1);
    chk("result", {16'd0, result}, {16'd0, er});
    if (ew) m_flags = ef;
    m_result = er;
    chk("flags", {28'd0, flags_out}, {28'd0, m_flags});
  endtask

  task automatic idle_check();
    start = 1'b0;
    scramble();
    @(posedge clk); #1;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_result", {16'd0, result}, {16'd0, m_result});
    chk("idle_flags", {28'd0, flags_out}, {28'd0, m_flags});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; func = 4'd0; operand_A = 16'd0; operand_B = 16'd0;
    c_in = 1'b0; csh = 1'b0; flag_en = 1'b0;
    m_result = 16'h0000; m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, flags_out}, 32'd0);
    rst_n = 1'b1;

    do_op(4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    chk("plan_add_r", {16'd0, result}, 32'h8000);
    chk("plan_add_f", {28'd0, flags_out}, 32'b1010);
    do_op(4'd2, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1);
    chk("plan_sub_f", {28'd0, flags_out}, 32'b0101);
    do_op(4'd3, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("plan_sbc_r", {16'd0, result}, 32'hFFFF);
    chk("plan_sbc_f", {28'd0, flags_out}, 32'b1000);
    do_op(4'd4, 16'hF0F0, 16'h0FF0, 1'b0, 1'b1, 1'b1);
    chk("plan_and_r", {16'd0, result}, 32'h00F0);
    chk("plan_and_f", {28'd0, flags_out}, 32'b0001);
    do_op(4'd6, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    chk("plan_ldst_r", {16'd0, result}, 32'h2345);
    chk("plan_ldst_f", {28'd0, flags_out}, 32'b0001);
    do_op(4'd8, 16'h0123, 16'h0456, 1'b0, 1'b0, 1'b1);
    chk("plan_mul_r", {16'd0, result}, 32'hEDC2);
    chk("plan_mul_f", {28'd0, flags_out}, 32'b1010);
    do_op(4'd9, 16'h0123, 16'h0456, 1'b0, 1'b0, 1'b1);
    chk("plan_mulh_r", {16'd0, result}, 32'h0004);
    chk("plan_mulh_f", {28'd0, flags_out}, 32'b0000);
    do_op(4'd0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    chk("plan_noflag_f", {28'd0, flags_out}, 32'b0000);
    idle_check();

    for (int i = 0; i < 200; i++) begin
      do_op(4'($urandom_range(0, 15)), pick(), pick(),
            1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) idle_check();
    end

    // Asynchronous reset in the middle of a multiply.
    func = 4'd8; operand_A = 16'hABCD; operand_B = 16'h1234; flag_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_result", {16'd0, result}, 32'd0);
    chk("rst_mid_flags", {28'd0, flags_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_result = 16'h0000;
    m_flags  = 4'b0000;
    do_op(4'd0, 16'h1000, 16'h0234, 1'b0, 1'b0, 1'b1);
    chk("post_rst_add", {16'd0, result}, 32'h1234);
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
